// File: rtl/membus_arbiter_if.sv
// Client and memory-side bus bundle for membus_arbiter.
// The c_lock signal exists only when MEMBUS_LOCK_EN is defined.
interface membus_arbiter_if #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8
);
   logic [NUM_CLIENTS-1:0]            c_req;
   logic [NUM_CLIENTS-1:0]            c_we;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_w_data;
   logic [NUM_CLIENTS-1:0]            c_gnt;
   logic [NUM_CLIENTS-1:0]            c_r_valid;
   logic [DATA_WIDTH-1:0]             c_r_data;
`ifdef MEMBUS_LOCK_EN
   logic [NUM_CLIENTS-1:0]            c_lock;
`endif
   logic [ADDR_WIDTH-1:0]             mem_addr;
   logic [DATA_WIDTH-1:0]             mem_w_data;
   logic                              mem_we;
   logic [DATA_WIDTH-1:0]             mem_r_data;

   modport master (
`ifdef MEMBUS_LOCK_EN
      output c_lock,
`endif
      output c_req, c_we, c_addr, c_w_data, mem_r_data,
      input  c_gnt, c_r_valid, c_r_data, mem_addr, mem_w_data, mem_we
   );

   modport slave (
`ifdef MEMBUS_LOCK_EN
      input  c_lock,
`endif
      input  c_req, c_we, c_addr, c_w_data, mem_r_data,
      output c_gnt, c_r_valid, c_r_data, mem_addr, mem_w_data, mem_we
   );
endinterface

// File: rtl/membus_arbiter.sv
// Round-robin arbiter of NUM_CLIENTS clients onto one synchronous memory port.
// Optional bus lock is compiled in with MEMBUS_LOCK_EN.
//
// Lock FSM (MEMBUS_LOCK_EN only)
//   state  | meaning
//   ARB    | round-robin arbitration among all requesters
//   LOCKED | only the lock owner may be granted; priority pointer frozen
module membus_arbiter #(
   parameter int NUM_CLIENTS  = 4,
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input logic             clk,
   input logic             rst_n,
   membus_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       ptr_nxt;
   logic [NUM_CLIENTS-1:0] req_eff;
   logic [NUM_CLIENTS-1:0] gnt;
   logic [PTR_W-1:0]       gnt_idx;
   logic                   gnt_any;
   logic [PTR_W:0]         scan;
   logic                   ptr_hold;
   logic [PTR_W-1:0]       sel;
   logic [NUM_CLIENTS-1:0] rd_pipe [READ_LATENCY];

`ifdef MEMBUS_LOCK_EN
   typedef enum logic {ARB, LOCKED} lock_state_t;

   lock_state_t      lock_state;
   logic [PTR_W-1:0] owner;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_state <= ARB;
         owner      <= '0;
      end else begin
         case (lock_state)
            ARB: begin
               if (gnt_any && bus.c_lock[gnt_idx]) begin
                  lock_state <= LOCKED;
                  owner      <= gnt_idx;
               end
            end
            LOCKED: begin
               if (!bus.c_lock[owner]) lock_state <= ARB;
            end
            default: lock_state <= ARB;
         endcase
      end
   end

   assign req_eff  = (lock_state == LOCKED) ? (bus.c_req & (NUM_CLIENTS'(1) << owner)) : bus.c_req;
   assign ptr_hold = (lock_state == LOCKED);
`else
   assign req_eff  = bus.c_req;
   assign ptr_hold = 1'b0;
`endif

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      scan    = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         scan = {1'b0, ptr} + (PTR_W+1)'(i);
         if (scan >= (PTR_W+1)'(NUM_CLIENTS)) scan = scan - (PTR_W+1)'(NUM_CLIENTS);
         if (!gnt_any && req_eff[scan[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[PTR_W-1:0];
         end
      end
      // grants stay masked during reset even if clients hold c_req
      if (!rst_n) gnt_any = 1'b0;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   assign ptr_nxt = (gnt_idx == PTR_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (gnt_any && !ptr_hold) begin
         ptr <= ptr_nxt;
      end
   end

   assign sel            = gnt_any ? gnt_idx : '0;
   assign bus.c_gnt      = gnt;
   assign bus.mem_we     = gnt_any & bus.c_we[gnt_idx];
   assign bus.mem_addr   = bus.c_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
   assign bus.mem_w_data = bus.c_w_data[sel*DATA_WIDTH +: DATA_WIDTH];

   // one-hot read tags travel alongside the memory's read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < READ_LATENCY; s++) rd_pipe[s] <= '0;
      end else begin
         rd_pipe[0] <= gnt & ~bus.c_we;
         for (int s = 1; s < READ_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
      end
   end

   assign bus.c_r_valid = rd_pipe[READ_LATENCY-1];
   assign bus.c_r_data  = bus.mem_r_data;
endmodule
